mmio_bus_arbiter: RTL and testbench
===================================

# mmio_bus_arbiter

Shares the CPU's data-memory/MMIO port between two requesters: the CPU load/store path and the debug unit that inspects memory and I/O. It grants one transaction at a time and decodes the address into data memory or the device region. Memory transactions run against a synchronous-read data memory. Device transactions use a valid/ready handshake with a timeout. It sits between the requesters and the data memory plus the device bank.

## Interface
- `ADDR_W`, 8: word-address width.
- `DATA_W`, 32: data width.
- `DEV_BASE`, 8'hF0: addresses `>= DEV_BASE` decode to the device region; lower addresses decode to data memory.
- `DEV_TIMEOUT`, 15: maximum number of DEV-state cycles waiting for `dev_ready`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `cpu_req`, `cpu_we`  in  1  CPU request and its write flag.
- `cpu_addr`  in  ADDR_W.
- `cpu_wdata`  in  DATA_W.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  DATA_W.
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_ack`, `dbg_rdata`: same meanings and widths as the CPU set, for the debug unit.
- `mem_en`  out  1.
- `mem_we`  out  1.
- `mem_addr`  out  ADDR_W.
- `mem_wdata`  out  DATA_W.
- `mem_rdata`  in  DATA_W  valid one cycle after `mem_en`.
- `dev_valid`  out  1.
- `dev_we`  out  1.
- `dev_addr`  out  ADDR_W.
- `dev_wdata`  out  DATA_W.
- `dev_ready`  in  1.
- `dev_rdata`  in  DATA_W  valid while `dev_ready` is high.
- `bus_err`  out  1  one-cycle pulse, coincident with the ack of a timed-out device access.

## Operation
- The FSM has five states: IDLE, MEM, MWAIT, DEV, DONE.
- IDLE:
  - Samples both `req` inputs and picks a winner (see Configuration).
  - Latches the winner's `we`/`addr`/`wdata` into the transaction registers and records the grant.
  - Goes to DEV if `addr >= DEV_BASE`, otherwise MEM.
  - With no request, stays in IDLE.
- MEM:
  - `mem_en=1`; `mem_we`, `mem_addr` and `mem_wdata` come from the latched fields.
  - A write goes to DONE; a read goes to MWAIT.
- MWAIT: latches `mem_rdata` into the read-data register, then goes to DONE.
- DEV:
  - `dev_valid=1` with the latched fields; the timeout counter increments each cycle.
  - When `dev_ready=1`, latches `dev_rdata` (reads only) and goes to DONE.
  - When the counter reaches `DEV_TIMEOUT` without `dev_ready`, goes to DONE with the read-data register set to all-ones and the error flag set.
- DONE:
  - Pulses the granted requester's `ack` for exactly one cycle, plus `bus_err` if the error flag is set.
  - Clears the error flag and timeout counter, then returns to IDLE.
- `cpu_rdata`/`dbg_rdata` each hold their last completed read value until that port's next read ack.
- A write ack leaves `rdata` unchanged.
- Requester rules:
  - Hold `req` high until `ack`, then drop it on the next edge.
  - `req` high in the IDLE cycle after an ack is a new request.
  - Fields are latched at grant; later changes are ignored.
  - Deasserting `req` after grant does not cancel the transaction; its ack still fires.
- Address compare is unsigned at `ADDR_W` width. No address translation: `dev_addr` is the full address.

## Timing
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- Memory read: `req` sampled in cycle 0, MEM in cycle 1, MWAIT in cycle 2, `ack` and `rdata` valid in cycle 3.
- Memory write: `ack` in cycle 2; the write commits in cycle 1.
- Device access: `dev_valid` from cycle 1; if `dev_ready` is first seen in cycle k, `ack` comes in cycle k+1.
- Device timeout: `dev_valid` stays high for exactly `DEV_TIMEOUT` cycles; `ack` and `bus_err` fire in cycle `DEV_TIMEOUT+1`.
- Back-to-back transactions: minimum 3 cycles (write) or 4 cycles (read) from one grant to the next.
- Reset:
  - State goes to IDLE; all outputs 0, including `rdata`.
  - Counter 0, error flag 0; the round-robin pointer is set so the CPU wins the first tie.
  - Reset mid-transaction aborts it with no ack; `mem_en`/`dev_valid` drop immediately.

## Configuration
- `ARB_RR_EN` defined: round-robin. On a simultaneous request, the requester not granted most recently wins. The pointer updates only on a grant.
- `ARB_RR_EN` undefined: fixed priority, CPU always wins ties. The debug unit is served only when `cpu_req=0` in IDLE.

## Test plan
- CPU write of 32'h1234_5678 to 8'h10, then read of 8'h10: write ack in cycle 2, read ack in cycle 3 with `cpu_rdata`=32'h1234_5678.
- Debug read of 8'hF4 with `dev_ready` raised 2 cycles after `dev_valid` and `dev_rdata`=32'h0000_00A5: `dbg_ack` with `dbg_rdata`=32'hA5; `cpu_ack` stays 0; `bus_err`=0.
- Device read of 8'hF0 with `dev_ready` held low: `dev_valid` high exactly 15 cycles, then `cpu_ack` and `bus_err` pulse together with `cpu_rdata`=32'hFFFF_FFFF.
- Both requesters hold `req` high for 4 transactions. With `ARB_RR_EN` defined, grants go CPU, DBG, CPU, DBG. Undefined, the CPU wins all 4 while `cpu_req` stays high.
- `rstn` pulled low during a device wait: `dev_valid`, all acks and all `rdata` go to 0 asynchronously. After release, a fresh CPU read of 8'h10 completes normally in 3 cycles.

Source files
------------

// File: rtl/mmio_bus_arbiter.sv
// mmio_bus_arbiter: shares the data-memory/MMIO port between the CPU and the debug unit, one transaction at a time.
// Define ARB_RR_EN for round-robin tie-breaking; left undefined, the CPU has fixed priority.
`timescale 1ns/1ps
module mmio_bus_arbiter #(
  parameter int                ADDR_W      = 8,
  parameter int                DATA_W      = 32,
  parameter logic [ADDR_W-1:0] DEV_BASE    = 8'hF0,
  parameter int                DEV_TIMEOUT = 15
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic              o_cpu_ack,
  output logic [DATA_W-1:0] o_cpu_rdata,
  input  logic              i_dbg_req,
  input  logic              i_dbg_we,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  input  logic [DATA_W-1:0] i_dbg_wdata,
  output logic              o_dbg_ack,
  output logic [DATA_W-1:0] o_dbg_rdata,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_dev_valid,
  output logic              o_dev_we,
  output logic [ADDR_W-1:0] o_dev_addr,
  output logic [DATA_W-1:0] o_dev_wdata,
  input  logic              i_dev_ready,
  input  logic [DATA_W-1:0] i_dev_rdata,
  output logic              o_bus_err
);

  // states: IDLE arbitrate+latch | MEM drive memory | MWAIT capture read | DEV device handshake | DONE ack pulse
  typedef enum logic [2:0] {
    S_IDLE,
    S_MEM,
    S_MWAIT,
    S_DEV,
    S_DONE
  } state_t;

  localparam int CNT_W = (DEV_TIMEOUT < 2) ? 1 : $clog2(DEV_TIMEOUT);

  state_t              r_state;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_gnt_dbg;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_err;
  logic [DATA_W-1:0]   r_cpu_rdata;
  logic [DATA_W-1:0]   r_dbg_rdata;
`ifdef ARB_RR_EN
  logic                r_last_dbg;
`endif

  logic                w_any_req;
  logic                w_pick_dbg;
  logic                w_req_we;
  logic [ADDR_W-1:0]   w_req_addr;
  logic [DATA_W-1:0]   w_req_wdata;
  logic                w_dev_to;
  logic                w_rd_load;
  logic [DATA_W-1:0]   w_rd_val;
  logic                w_in_mem;
  logic                w_in_dev;
  logic                w_in_done;

  assign w_any_req = i_cpu_req | i_dbg_req;

`ifdef ARB_RR_EN
  // On a tie, whoever was not granted last wins.
  assign w_pick_dbg = i_dbg_req & (~i_cpu_req | ~r_last_dbg);
`else
  assign w_pick_dbg = i_dbg_req & ~i_cpu_req;
`endif

  assign w_req_we    = w_pick_dbg ? i_dbg_we    : i_cpu_we;
  assign w_req_addr  = w_pick_dbg ? i_dbg_addr  : i_cpu_addr;
  assign w_req_wdata = w_pick_dbg ? i_dbg_wdata : i_cpu_wdata;

  assign w_dev_to = (r_cnt == CNT_W'(DEV_TIMEOUT - 1));

  always_comb begin
    w_rd_load = 1'b0;
    w_rd_val  = '0;
    case (r_state)
      S_MWAIT: begin
        w_rd_load = 1'b1;
        w_rd_val  = i_mem_rdata;
      end
      S_DEV: begin
        if (i_dev_ready) begin
          w_rd_load = ~r_we;
          w_rd_val  = i_dev_rdata;
        end else if (w_dev_to) begin
          w_rd_load = ~r_we;
          w_rd_val  = '1;
        end
      end
      default: begin
        w_rd_load = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state     <= S_IDLE;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_gnt_dbg   <= 1'b0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_cpu_rdata <= '0;
      r_dbg_rdata <= '0;
`ifdef ARB_RR_EN
      r_last_dbg  <= 1'b1;
`endif
    end else begin
      if (w_rd_load) begin
        if (r_gnt_dbg) r_dbg_rdata <= w_rd_val;
        else           r_cpu_rdata <= w_rd_val;
      end
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_we      <= w_req_we;
            r_addr    <= w_req_addr;
            r_wdata   <= w_req_wdata;
            r_gnt_dbg <= w_pick_dbg;
`ifdef ARB_RR_EN
            r_last_dbg <= w_pick_dbg;
`endif
            r_state   <= (w_req_addr >= DEV_BASE) ? S_DEV : S_MEM;
          end
        end
        S_MEM: begin
          r_state <= r_we ? S_DONE : S_MWAIT;
        end
        S_MWAIT: begin
          r_state <= S_DONE;
        end
        S_DEV: begin
          // A ready arriving on the final allowed cycle still counts as success.
          if (i_dev_ready) begin
            r_state <= S_DONE;
          end else if (w_dev_to) begin
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          r_err   <= 1'b0;
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign w_in_mem  = (r_state == S_MEM);
  assign w_in_dev  = (r_state == S_DEV);
  assign w_in_done = (r_state == S_DONE);

  assign o_mem_en    = w_in_mem;
  assign o_mem_we    = w_in_mem & r_we;
  assign o_mem_addr  = w_in_mem ? r_addr  : '0;
  assign o_mem_wdata = w_in_mem ? r_wdata : '0;

  assign o_dev_valid = w_in_dev;
  assign o_dev_we    = w_in_dev & r_we;
  assign o_dev_addr  = w_in_dev ? r_addr  : '0;
  assign o_dev_wdata = w_in_dev ? r_wdata : '0;

  assign o_cpu_ack   = w_in_done & ~r_gnt_dbg;
  assign o_dbg_ack   = w_in_done &  r_gnt_dbg;
  assign o_bus_err   = w_in_done &  r_err;
  assign o_cpu_rdata = r_cpu_rdata;
  assign o_dbg_rdata = r_dbg_rdata;

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Self-checking bench for mmio_bus_arbiter: behavioural memory and device models, scoreboard of expected acks.
`timescale 1ns/1ps
module tb_mmio_bus_arbiter;
  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int TOUT = 15;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic cpu_req = 1'b0, cpu_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0, dbg_addr = '0;
  logic [DW-1:0] cpu_wdata = '0, dbg_wdata = '0;
  logic cpu_ack, dbg_ack, mem_en, mem_we, dev_valid, dev_we, dev_ready, bus_err;
  logic [AW-1:0] mem_addr, dev_addr;
  logic [DW-1:0] cpu_rdata, dbg_rdata, mem_wdata, mem_rdata, dev_wdata, dev_rdata;

  always #5 clk = ~clk;

  mmio_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEV_BASE(8'hF0), .DEV_TIMEOUT(TOUT)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_ack(cpu_ack), .o_cpu_rdata(cpu_rdata),
    .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr), .i_dbg_wdata(dbg_wdata),
    .o_dbg_ack(dbg_ack), .o_dbg_rdata(dbg_rdata),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata),
    .o_dev_valid(dev_valid), .o_dev_we(dev_we), .o_dev_addr(dev_addr), .o_dev_wdata(dev_wdata),
    .i_dev_ready(dev_ready), .i_dev_rdata(dev_rdata),
    .o_bus_err(bus_err)
  );

  // synchronous-read data memory
  logic [DW-1:0] mem_arr [0:255];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_arr[mem_addr] <= mem_wdata;
      mem_rdata <= mem_arr[mem_addr];
    end
  end

  // device: ready appears dev_delay cycles after the first dev_valid cycle; -1 never answers
  int dev_delay = -1;
  logic [DW-1:0] dev_data = '0;
  int dv_cnt = 0;
  always @(posedge clk) dv_cnt <= dev_valid ? dv_cnt + 1 : 0;
  assign dev_ready = dev_valid && (dev_delay >= 0) && (dv_cnt == dev_delay);
  assign dev_rdata = dev_ready ? dev_data : 32'hDEAD_BEEF;

  typedef struct {
    logic          dbg;
    logic [DW-1:0] rdata;
    logic          err;
    int            lat;
    int            dv;
  } exp_t;
  exp_t exp_q[$];

  int total = 0;
  int bad = 0;
  logic tb_last_dbg = 1'b1;
  logic [DW-1:0] tb_cpu_rd = '0;
  logic [DW-1:0] tb_dbg_rd = '0;

  task automatic push_exp(input logic dbg, input logic we, input logic [DW-1:0] rd,
                          input logic err, input int lat, input int dv);
    exp_t e;
    if (!we) begin
      if (dbg) tb_dbg_rd = rd;
      else     tb_cpu_rd = rd;
    end
    e.dbg   = dbg;
    e.rdata = dbg ? tb_dbg_rd : tb_cpu_rd;
    e.err   = err;
    e.lat   = lat;
    e.dv    = dv;
    tb_last_dbg = dbg;
    exp_q.push_back(e);
  endtask

  // Issues one request in the IDLE cycle (cycle 0) and reports what the DUT did; fields are scrambled after grant.
  task automatic run_txn(input logic dbg, input logic we, input logic hold,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         output logic g_dbg, output logic [DW-1:0] g_rd, output logic g_err,
                         output int g_lat, output int g_dv, output logic g_both,
                         output logic [AW+DW:0] g_dev);
    logic done;
    logic seen_dev;
    done = 1'b0; seen_dev = 1'b0;
    g_dbg = 1'b0; g_rd = '0; g_err = 1'b0; g_lat = 0; g_dv = 0; g_both = 1'b0; g_dev = '0;
    @(negedge clk);
    if (dbg) begin dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wd; end
    else     begin cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; end
    while (!done && g_lat < 40) begin
      @(negedge clk);
      g_lat++;
      if (g_lat == 1) begin
        if (dbg) begin dbg_we = ~we; dbg_addr = ~addr; dbg_wdata = ~wd; dbg_req = hold; end
        else     begin cpu_we = ~we; cpu_addr = ~addr; cpu_wdata = ~wd; cpu_req = hold; end
      end
      if (dev_valid) begin
        if (!seen_dev) g_dev = {dev_we, dev_addr, dev_wdata};
        seen_dev = 1'b1;
        g_dv++;
      end
      if (cpu_ack || dbg_ack) begin
        g_dbg  = dbg_ack;
        g_both = cpu_ack & dbg_ack;
        g_rd   = dbg_ack ? dbg_rdata : cpu_rdata;
        g_err  = bus_err;
        done   = 1'b1;
        cpu_req = 1'b0;
        dbg_req = 1'b0;
      end
    end
    if (!done) begin cpu_req = 1'b0; dbg_req = 1'b0; g_lat = -1; end
  endtask

  task automatic test_reset();
    #3 rstn = 1'b0;
    tb_last_dbg = 1'b1; tb_cpu_rd = '0; tb_dbg_rd = '0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    total++; if ({cpu_ack, dbg_ack, mem_en, mem_we, dev_valid, dev_we, bus_err} !== 7'b0) begin
      bad++; $display("FAIL reset_ctl: got %b want 0000000", {cpu_ack, dbg_ack, mem_en, mem_we, dev_valid, dev_we, bus_err});
    end
    total++; if (cpu_rdata !== 32'h0) begin bad++; $display("FAIL reset_cpu_rdata: got %h want 0", cpu_rdata); end
    total++; if (dbg_rdata !== 32'h0) begin bad++; $display("FAIL reset_dbg_rdata: got %h want 0", dbg_rdata); end
    total++; if ({mem_addr, mem_wdata, dev_addr, dev_wdata} !== '0) begin
      bad++; $display("FAIL reset_bus: got %h want 0", {mem_addr, mem_wdata, dev_addr, dev_wdata});
    end
    rstn = 1'b1;
    @(negedge clk);
    total++; if ({mem_en, dev_valid, cpu_ack, dbg_ack} !== 4'b0) begin
      bad++; $display("FAIL idle_after_reset: got %b want 0000", {mem_en, dev_valid, cpu_ack, dbg_ack});
    end
  endtask

  typedef struct {
    logic          dbg;
    logic          we;
    logic          hold;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } mrow_t;

  task automatic test_mem_path();
    mrow_t rows [8];
    exp_t e;
    logic g_dbg, g_err, g_both;
    logic [DW-1:0] g_rd;
    logic [AW+DW:0] g_dev;
    int g_lat, g_dv;
    rows = '{'{1'b0, 1'b1, 1'b1, 8'h10, 32'h1234_5678},
             '{1'b0, 1'b0, 1'b1, 8'h10, 32'h1234_5678},
             '{1'b1, 1'b1, 1'b0, 8'h22, 32'hCAFE_F00D},
             '{1'b1, 1'b0, 1'b0, 8'h22, 32'hCAFE_F00D},
             '{1'b0, 1'b1, 1'b1, 8'h11, 32'h0BAD_C0DE},
             '{1'b0, 1'b0, 1'b0, 8'h22, 32'hCAFE_F00D},
             '{1'b1, 1'b1, 1'b1, 8'hEF, 32'h0000_00EF},
             '{1'b1, 1'b0, 1'b1, 8'hEF, 32'h0000_00EF}};
    foreach (rows[i]) begin
      push_exp(rows[i].dbg, rows[i].we, rows[i].data, 1'b0, rows[i].we ? 2 : 3, 0);
      run_txn(rows[i].dbg, rows[i].we, rows[i].hold, rows[i].addr, rows[i].data,
              g_dbg, g_rd, g_err, g_lat, g_dv, g_both, g_dev);
      e = exp_q.pop_front();
      total++; if (g_lat != e.lat) begin bad++; $display("FAIL mem[%0d]_lat: got %0d want %0d", i, g_lat, e.lat); end
      total++; if (g_dbg !== e.dbg) begin bad++; $display("FAIL mem[%0d]_port: got dbg=%b want dbg=%b", i, g_dbg, e.dbg); end
      total++; if (g_rd !== e.rdata) begin bad++; $display("FAIL mem[%0d]_rdata: got %h want %h", i, g_rd, e.rdata); end
      total++; if (g_err !== e.err) begin bad++; $display("FAIL mem[%0d]_err: got %b want %b", i, g_err, e.err); end
      total++; if (g_dv != e.dv) begin bad++; $display("FAIL mem[%0d]_devvalid: got %0d want %0d", i, g_dv, e.dv); end
      total++; if (g_both !== 1'b0) begin bad++; $display("FAIL mem[%0d]_dual_ack: got %b want 0", i, g_both); end
    end
    total++; if (mem_arr[8'h10] !== 32'h1234_5678) begin bad++; $display("FAIL mem_cell10: got %h want 12345678", mem_arr[8'h10]); end
    total++; if (mem_arr[8'h11] !== 32'h0BAD_C0DE) begin bad++; $display("FAIL mem_cell11: got %h want 0badc0de", mem_arr[8'h11]); end
    total++; if (dbg_rdata !== tb_dbg_rd) begin bad++; $display("FAIL mem_dbg_hold: got %h want %h", dbg_rdata, tb_dbg_rd); end
    total++; if (cpu_rdata !== tb_cpu_rd) begin bad++; $display("FAIL mem_cpu_hold: got %h want %h", cpu_rdata, tb_cpu_rd); end
  endtask

  typedef struct {
    logic          dbg;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    int            delay;
    logic [DW-1:0] rdata;
  } drow_t;

  task automatic test_dev_path();
    drow_t rows [5];
    exp_t e;
    logic g_dbg, g_err, g_both;
    logic [DW-1:0] g_rd;
    logic [AW+DW:0] g_dev;
    int g_lat, g_dv;
    logic to;
    rows = '{'{1'b1, 1'b0, 8'hF4, 32'h0000_0000, 2,  32'h0000_00A5},
             '{1'b0, 1'b1, 8'hF8, 32'h5555_AAAA, 0,  32'h0000_0000},
             '{1'b0, 1'b0, 8'hF0, 32'h0000_0000, -1, 32'h0000_0000},
             '{1'b1, 1'b1, 8'hFF, 32'h1357_9BDF, -1, 32'h0000_0000},
             '{1'b0, 1'b0, 8'hF0, 32'h0000_0000, 14, 32'h0BAD_F00D}};
    foreach (rows[i]) begin
      dev_delay = rows[i].delay;
      dev_data  = rows[i].rdata;
      to = (rows[i].delay < 0);
      push_exp(rows[i].dbg, rows[i].we, to ? 32'hFFFF_FFFF : rows[i].rdata, to,
               to ? TOUT + 1 : rows[i].delay + 2, to ? TOUT : rows[i].delay + 1);
      run_txn(rows[i].dbg, rows[i].we, 1'b1, rows[i].addr, rows[i].wd,
              g_dbg, g_rd, g_err, g_lat, g_dv, g_both, g_dev);
      e = exp_q.pop_front();
      total++; if (g_lat != e.lat) begin bad++; $display("FAIL dev[%0d]_lat: got %0d want %0d", i, g_lat, e.lat); end
      total++; if (g_dbg !== e.dbg) begin bad++; $display("FAIL dev[%0d]_port: got dbg=%b want dbg=%b", i, g_dbg, e.dbg); end
      total++; if (g_rd !== e.rdata) begin bad++; $display("FAIL dev[%0d]_rdata: got %h want %h", i, g_rd, e.rdata); end
      total++; if (g_err !== e.err) begin bad++; $display("FAIL dev[%0d]_bus_err: got %b want %b", i, g_err, e.err); end
      total++; if (g_dv != e.dv) begin bad++; $display("FAIL dev[%0d]_valid_cycles: got %0d want %0d", i, g_dv, e.dv); end
      total++; if (g_both !== 1'b0) begin bad++; $display("FAIL dev[%0d]_dual_ack: got %b want 0", i, g_both); end
      total++; if (g_dev !== {rows[i].we, rows[i].addr, rows[i].wd}) begin
        bad++; $display("FAIL dev[%0d]_fields: got %h want %h", i, g_dev, {rows[i].we, rows[i].addr, rows[i].wd});
      end
    end
    dev_delay = -1;
    total++; if (dbg_rdata !== tb_dbg_rd) begin bad++; $display("FAIL dev_dbg_hold: got %h want %h", dbg_rdata, tb_dbg_rd); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int lat;
    int n;
    logic win;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h30; cpu_wdata = 32'h0000_0C0C;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h31; dbg_wdata = 32'h0000_0D0D;
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_RR_EN
      win = ~tb_last_dbg;
`else
      win = 1'b0;
`endif
      push_exp(win, 1'b1, '0, 1'b0, 2 + 3 * i, 0);
    end
    lat = 0;
    n = 0;
    while (n < 4 && lat < 60) begin
      @(negedge clk);
      lat++;
      if (cpu_ack || dbg_ack) begin
        e = exp_q.pop_front();
        total++; if ({cpu_ack, dbg_ack} !== {~e.dbg, e.dbg}) begin
          bad++; $display("FAIL arb[%0d]_grant: got cpu/dbg=%b%b want %b%b", n, cpu_ack, dbg_ack, ~e.dbg, e.dbg);
        end
        total++; if (lat != e.lat) begin bad++; $display("FAIL arb[%0d]_lat: got %0d want %0d", n, lat, e.lat); end
        n++;
        if (n == 4) begin cpu_req = 1'b0; dbg_req = 1'b0; end
      end
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    exp_q.delete();
    total++; if (n != 4) begin bad++; $display("FAIL arb_ack_count: got %0d want 4", n); end
    total++; if (mem_arr[8'h30] !== 32'h0000_0C0C) begin bad++; $display("FAIL arb_cell30: got %h want 00000c0c", mem_arr[8'h30]); end
`ifdef ARB_RR_EN
    total++; if (mem_arr[8'h31] !== 32'h0000_0D0D) begin bad++; $display("FAIL arb_cell31: got %h want 00000d0d", mem_arr[8'h31]); end
`endif
    @(negedge clk);
  endtask

  task automatic test_reset_midway();
    exp_t e;
    logic g_dbg, g_err, g_both;
    logic [DW-1:0] g_rd;
    logic [AW+DW:0] g_dev;
    int g_lat, g_dv;
    logic seen_ack;
    dev_delay = -1;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'hF0; cpu_wdata = '0;
    repeat (5) @(negedge clk);
    total++; if (dev_valid !== 1'b1) begin bad++; $display("FAIL rstmid_pre_valid: got %b want 1", dev_valid); end
    #2 rstn = 1'b0;
    cpu_req = 1'b0;
    #1;
    total++; if ({dev_valid, mem_en, cpu_ack, dbg_ack, bus_err} !== 5'b0) begin
      bad++; $display("FAIL rstmid_ctl: got %b want 00000", {dev_valid, mem_en, cpu_ack, dbg_ack, bus_err});
    end
    total++; if ({cpu_rdata, dbg_rdata} !== '0) begin
      bad++; $display("FAIL rstmid_rdata: got %h %h want 0 0", cpu_rdata, dbg_rdata);
    end
    tb_last_dbg = 1'b1; tb_cpu_rd = '0; tb_dbg_rd = '0;
    exp_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    seen_ack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (cpu_ack || dbg_ack || dev_valid) seen_ack = 1'b1;
    end
    total++; if (seen_ack !== 1'b0) begin bad++; $display("FAIL rstmid_aborted: got activity=%b want 0", seen_ack); end
    push_exp(1'b0, 1'b0, 32'h1234_5678, 1'b0, 3, 0);
    run_txn(1'b0, 1'b0, 1'b1, 8'h10, 32'h0, g_dbg, g_rd, g_err, g_lat, g_dv, g_both, g_dev);
    e = exp_q.pop_front();
    total++; if (g_lat != e.lat) begin bad++; $display("FAIL rstmid_read_lat: got %0d want %0d", g_lat, e.lat); end
    total++; if (g_dbg !== e.dbg) begin bad++; $display("FAIL rstmid_read_port: got dbg=%b want dbg=%b", g_dbg, e.dbg); end
    total++; if (g_rd !== e.rdata) begin bad++; $display("FAIL rstmid_read_data: got %h want %h", g_rd, e.rdata); end
    total++; if (g_err !== e.err) begin bad++; $display("FAIL rstmid_read_err: got %b want %b", g_err, e.err); end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_mem_path();
    test_dev_path();
    test_back_to_back();
    test_reset_midway();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
